// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl_pkg
//  Description : Shared constants and state encoding for the CPU run controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_ctrl_pkg;

    localparam int unsigned c_DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_RESET = 2'd1;
    localparam state_t c_ST_RUN   = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl_if
//  Description : Control/status bundle between the run controller and its host.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if
    import cpu_run_ctrl_pkg::*;
();

    logic                start;
    logic                abort;
    logic [c_DATA_W-1:0] reg_a0;
    logic                cpu_rst;
    logic                cpu_halt;
    logic                done;
    logic                timeout;
    logic                aborted;
    logic [c_DATA_W-1:0] result;
    logic [c_DATA_W-1:0] cycles;

    modport master (
        output start, abort, reg_a0,
        input  cpu_rst, cpu_halt, done, timeout, aborted, result, cycles
    );

    modport slave (
        input  start, abort, reg_a0,
        output cpu_rst, cpu_halt, done, timeout, aborted, result, cycles
    );

endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl_a0_stable_detect.sv
`default_nettype none
// ============================================================================
//  Module      : a0_stable_detect
//  Description : Tracks how many consecutive cycles reg_a0 has not changed.
//  Revision    : 1.0 - initial release
// ============================================================================
module a0_stable_detect
    import cpu_run_ctrl_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clear,
    input  wire logic [c_DATA_W-1:0] value,
    output logic      [c_DATA_W-1:0] stable_cnt
);

    logic [c_DATA_W-1:0] r_a0_prev;
    logic [c_DATA_W-1:0] r_cnt;
    logic [c_DATA_W-1:0] w_cnt_next;

    // stable_cnt is the post-update count so the caller can exit in the same cycle
    always_comb begin
        w_cnt_next = r_cnt;
        if (clear || (value != r_a0_prev)) begin
            w_cnt_next = '0;
        end else if (r_cnt != '1) begin
            w_cnt_next = r_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a0_prev <= '0;
            r_cnt     <= '0;
        end else begin
            r_a0_prev <= value;
            r_cnt     <= w_cnt_next;
        end
    end

    assign stable_cnt = w_cnt_next;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Sequences reset/run/halt of a CPU core and latches its result.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned MAX_CYCLES    = 2000,
    parameter int unsigned STABLE_CYCLES = 64
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cpu_run_ctrl_if.slave bus
);

    localparam logic [c_DATA_W-1:0] c_HOLD_LAST  = c_DATA_W'(RST_CYCLES - 1);
    localparam logic [c_DATA_W-1:0] c_MAX_CYC    = c_DATA_W'(MAX_CYCLES);
    localparam logic [c_DATA_W-1:0] c_STABLE_CYC = c_DATA_W'(STABLE_CYCLES);

    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("cpu_run_ctrl: RST_CYCLES must be at least 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max_cycles
        $error("cpu_run_ctrl: MAX_CYCLES must be at least 1");
    end

    state_t              r_state,   w_state_next;
    logic [c_DATA_W-1:0] r_hold,    w_hold_next;
    logic [c_DATA_W-1:0] r_cycles,  w_cycles_next;
    logic [c_DATA_W-1:0] r_result,  w_result_next;
    logic                r_timeout, w_timeout_next;
    logic                r_aborted, w_aborted_next;
    logic [c_DATA_W-1:0] w_cycles_inc;
    logic [c_DATA_W-1:0] w_stable_cnt;
    logic                w_stable_clear;
    logic                w_stable_hit;

    // cycles is zero only on the first RUN cycle, which restarts the stability window
    assign w_stable_clear = (r_state != c_ST_RUN) || (r_cycles == '0);

    a0_stable_detect u_stable (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_stable_clear),
        .value      (bus.reg_a0),
        .stable_cnt (w_stable_cnt)
    );

    assign w_stable_hit = (STABLE_CYCLES != 0) && (w_stable_cnt == c_STABLE_CYC);

    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold;
        w_cycles_next  = r_cycles;
        w_result_next  = r_result;
        w_timeout_next = r_timeout;
        w_aborted_next = r_aborted;
        w_cycles_inc   = r_cycles + 32'd1;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    w_state_next   = c_ST_RESET;
                    w_hold_next    = '0;
                    w_cycles_next  = '0;
                    w_result_next  = '0;
                    w_timeout_next = 1'b0;
                    w_aborted_next = 1'b0;
                end
            end
            c_ST_RESET: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_state_next = c_ST_RUN;
                end else begin
                    w_hold_next = r_hold + 32'd1;
                end
            end
            c_ST_RUN: begin
                w_cycles_next = w_cycles_inc;
                if (bus.abort) begin
                    w_aborted_next = 1'b1;
                    w_result_next  = bus.reg_a0;
                    w_state_next   = c_ST_DONE;
                end else if (w_stable_hit) begin
                    w_result_next  = bus.reg_a0;
                    w_state_next   = c_ST_DONE;
                end else if (w_cycles_inc == c_MAX_CYC) begin
                    w_timeout_next = 1'b1;
                    w_result_next  = bus.reg_a0;
                    w_state_next   = c_ST_DONE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_hold    <= '0;
            r_cycles  <= '0;
            r_result  <= '0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hold    <= w_hold_next;
            r_cycles  <= w_cycles_next;
            r_result  <= w_result_next;
            r_timeout <= w_timeout_next;
            r_aborted <= w_aborted_next;
        end
    end

    assign bus.cpu_rst  = (r_state == c_ST_IDLE) || (r_state == c_ST_RESET);
    assign bus.cpu_halt = (r_state == c_ST_DONE);
    assign bus.done     = (r_state == c_ST_DONE);
    assign bus.timeout  = r_timeout;
    assign bus.aborted  = r_aborted;
    assign bus.result   = r_result;
    assign bus.cycles   = r_cycles;

endmodule
`default_nettype wire
